// File: rtl/video_pkg.sv
// Shared 720p video constants, colour types and motion encoding for the HDMI pattern path.
package video_pkg;

    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned H_FRONT_720P  = 110;
    localparam int unsigned H_SYNC_720P   = 40;
    localparam int unsigned H_BACK_720P   = 220;
    localparam int unsigned H_TOTAL_720P  = 1650;
    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned V_FRONT_720P  = 5;
    localparam int unsigned V_SYNC_720P   = 5;
    localparam int unsigned V_BACK_720P   = 20;
    localparam int unsigned V_TOTAL_720P  = 750;

    localparam int unsigned RGB_BITS = 8;

    typedef struct packed {
        logic [RGB_BITS-1:0] r;
        logic [RGB_BITS-1:0] g;
        logic [RGB_BITS-1:0] b;
    } rgb_t;

    localparam rgb_t FG_DEFAULT = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t BG_DEFAULT = '{r: 8'h00, g: 8'h00, b: 8'h8B};

    // Encoding is {moving_left, moving_up} so a reflection is a single bit flip.
    typedef enum logic [1:0] {
        DirRightDown = 2'b00,
        DirRightUp   = 2'b01,
        DirLeftDown  = 2'b10,
        DirLeftUp    = 2'b11
    } dir_t;

endpackage

// File: rtl/square_motion.sv
// Square position registers and direction state machine; moves once per unpaused frame
// and pulses o_bounce for one cycle whenever either axis reflects.
module square_motion
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
    parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
    parameter int unsigned SQ_SIZE  = 200,
    parameter int unsigned STEP     = 2,
    parameter int unsigned X_W      = 11,
    parameter int unsigned Y_W      = 10
) (
    input  logic           i_clk_pxl,
    input  logic           i_reset,
    input  logic           i_nf,
    input  logic           i_pause,
    output logic [X_W-1:0] o_sq_x,
    output logic [Y_W-1:0] o_sq_y,
    output logic           o_bounce
);

    localparam logic [X_W:0] X_MAX  = (X_W+1)'(H_ACTIVE - SQ_SIZE);
    localparam logic [X_W:0] X_STEP = (X_W+1)'(STEP);
    localparam logic [Y_W:0] Y_MAX  = (Y_W+1)'(V_ACTIVE - SQ_SIZE);
    localparam logic [Y_W:0] Y_STEP = (Y_W+1)'(STEP);

    dir_t           dir_q;
    logic           moving_left;
    logic           moving_up;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           x_flip;
    logic           y_flip;

    always_comb begin
        moving_left = dir_q inside {DirLeftDown, DirLeftUp};
        moving_up   = dir_q inside {DirRightUp, DirLeftUp};
        x_sum       = {1'b0, o_sq_x} + X_STEP;
        y_sum       = {1'b0, o_sq_y} + Y_STEP;
        x_next      = o_sq_x;
        y_next      = o_sq_y;
        x_flip      = 1'b0;
        y_flip      = 1'b0;

        if (!moving_left) begin
            if (x_sum >= X_MAX) begin
                x_next = X_MAX[X_W-1:0];
                x_flip = 1'b1;
            end else begin
                x_next = x_sum[X_W-1:0];
            end
        end else if ({1'b0, o_sq_x} <= X_STEP) begin
            x_next = '0;
            x_flip = 1'b1;
        end else begin
            x_next = o_sq_x - X_STEP[X_W-1:0];
        end

        if (!moving_up) begin
            if (y_sum >= Y_MAX) begin
                y_next = Y_MAX[Y_W-1:0];
                y_flip = 1'b1;
            end else begin
                y_next = y_sum[Y_W-1:0];
            end
        end else if ({1'b0, o_sq_y} <= Y_STEP) begin
            y_next = '0;
            y_flip = 1'b1;
        end else begin
            y_next = o_sq_y - Y_STEP[Y_W-1:0];
        end
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            o_sq_x   <= '0;
            o_sq_y   <= '0;
            dir_q    <= DirRightDown;
            o_bounce <= 1'b0;
        end else begin
            o_bounce <= 1'b0;
            if (i_nf && !i_pause) begin
                o_sq_x   <= x_next;
                o_sq_y   <= y_next;
                // A corner hit flips both bits but still yields a single pulse.
                dir_q    <= dir_t'({moving_left ^ x_flip, moving_up ^ y_flip});
                o_bounce <= x_flip | y_flip;
            end
        end
    end

endmodule

// File: rtl/bouncing_square_painter.sv
// Pixel-colour stage: hit-tests the moving square, selects FG/BG colour and delays
// sync/DE through a two-stage pipeline so everything leaves together.
module bouncing_square_painter
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_720P,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_720P,
    parameter int unsigned SQ_SIZE     = 200,
    parameter int unsigned STEP        = 2,
    parameter int unsigned X_W         = 11,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned COLOUR_BITS = 8,
    parameter logic [3*COLOUR_BITS-1:0] FG_RGB = FG_DEFAULT,
    parameter logic [3*COLOUR_BITS-1:0] BG_RGB = BG_DEFAULT
) (
    input  logic                   i_clk_pxl,
    input  logic                   i_reset,
    input  logic [X_W-1:0]         i_sx,
    input  logic [Y_W-1:0]         i_sy,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_de,
    input  logic                   i_nf,
    input  logic                   i_pause,
    output logic [COLOUR_BITS-1:0] o_r,
    output logic [COLOUR_BITS-1:0] o_g,
    output logic [COLOUR_BITS-1:0] o_b,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [X_W-1:0]         o_sq_x,
    output logic [Y_W-1:0]         o_sq_y,
    output logic                   o_bounce
);

    localparam int unsigned MIN_ACTIVE = (H_ACTIVE < V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
    localparam logic [X_W:0] X_SIZE = (X_W+1)'(SQ_SIZE);
    localparam logic [Y_W:0] Y_SIZE = (Y_W+1)'(SQ_SIZE);

    if (SQ_SIZE >= H_ACTIVE) begin : g_chk_h
        $fatal(1, "SQ_SIZE must be smaller than H_ACTIVE");
    end
    if (SQ_SIZE >= V_ACTIVE) begin : g_chk_v
        $fatal(1, "SQ_SIZE must be smaller than V_ACTIVE");
    end
    if (SQ_SIZE < MIN_ACTIVE && STEP >= MIN_ACTIVE - SQ_SIZE) begin : g_chk_step
        $fatal(1, "STEP must be smaller than the square's travel range");
    end

    logic [X_W-1:0]           sq_x;
    logic [Y_W-1:0]           sq_y;
    logic                     hit;
    logic                     s1_inside_q;
    logic                     s1_de_q;
    logic                     s1_hsync_q;
    logic                     s1_vsync_q;
    logic [3*COLOUR_BITS-1:0] colour;
    logic [3*COLOUR_BITS-1:0] rgb_q;

    square_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SQ_SIZE  (SQ_SIZE),
        .STEP     (STEP),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_motion (
        .i_clk_pxl (i_clk_pxl),
        .i_reset   (i_reset),
        .i_nf      (i_nf),
        .i_pause   (i_pause),
        .o_sq_x    (sq_x),
        .o_sq_y    (sq_y),
        .o_bounce  (o_bounce)
    );

    assign o_sq_x = sq_x;
    assign o_sq_y = sq_y;

    // Upper bounds widened by one bit so a square near the far edge cannot wrap.
    always_comb begin
        hit = (i_sx >= sq_x) && ({1'b0, i_sx} < ({1'b0, sq_x} + X_SIZE)) &&
              (i_sy >= sq_y) && ({1'b0, i_sy} < ({1'b0, sq_y} + Y_SIZE));
    end

    always_comb begin
        colour = '0;
        if (s1_de_q) begin
            colour = s1_inside_q ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            s1_inside_q <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_hsync_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            rgb_q       <= '0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_de        <= 1'b0;
        end else begin
            s1_inside_q <= hit;
            s1_de_q     <= i_de;
            s1_hsync_q  <= i_hsync;
            s1_vsync_q  <= i_vsync;
            rgb_q       <= colour;
            o_hsync     <= s1_hsync_q;
            o_vsync     <= s1_vsync_q;
            o_de        <= s1_de_q;
        end
    end

    assign o_r = rgb_q[3*COLOUR_BITS-1 -: COLOUR_BITS];
    assign o_g = rgb_q[2*COLOUR_BITS-1 -: COLOUR_BITS];
    assign o_b = rgb_q[COLOUR_BITS-1:0];

endmodule
